// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: single-outstanding imem requests, pushes {pc, inst}
// into the instruction queue, holds a word while the queue is full, and handles redirects.
module inst_fetch_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   output logic                           imem_req,
   output logic [ADDR_WIDTH-1:0]          imem_addr,
   input  logic                           imem_valid,
   input  logic [INST_WIDTH-1:0]          imem_data,
   input  logic                           redirect_valid,
   input  logic [ADDR_WIDTH-1:0]          redirect_pc,
   input  logic                           q_full,
   output logic                           q_write,
   output logic [ADDR_WIDTH+INST_WIDTH-1:0] q_data,
   output logic                           q_clear
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2,
      DROP = 2'd3
   } state_t;

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
   logic [ADDR_WIDTH-1:0]   hold_pc_reg, hold_pc_next;
   logic [INST_WIDTH-1:0]   hold_inst_reg, hold_inst_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         pc_reg        <= RESET_PC;
         hold_pc_reg   <= '0;
         hold_inst_reg <= '0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         hold_pc_reg   <= hold_pc_next;
         hold_inst_reg <= hold_inst_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      hold_pc_next   = hold_pc_reg;
      hold_inst_next = hold_inst_reg;
      imem_req       = 1'b0;
      imem_addr      = '0;
      q_write        = 1'b0;
      q_data         = '0;
      q_clear        = 1'b0;

      // Every output is held at zero during reset.
      if (!rst) begin
         imem_addr = pc_reg;
         q_clear   = redirect_valid;
         if (redirect_valid) begin
            pc_next = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            case (state_reg)
               // A response is still owed unless it arrives in this very cycle.
               WAIT, DROP: state_next = imem_valid ? IDLE : DROP;
               default:    state_next = IDLE;
            endcase
         end else begin
            case (state_reg)
               IDLE: begin
                  if (!q_full) begin
                     imem_req   = 1'b1;
                     state_next = WAIT;
                  end
               end
               WAIT: begin
                  if (imem_valid) begin
                     pc_next = pc_reg + ADDR_WIDTH'(4);
                     if (!q_full) begin
                        q_write    = 1'b1;
                        q_data     = {pc_reg, imem_data};
                        state_next = IDLE;
                     end else begin
                        hold_pc_next   = pc_reg;
                        hold_inst_next = imem_data;
                        state_next     = HOLD;
                     end
                  end
               end
               HOLD: begin
                  if (!q_full) begin
                     q_write    = 1'b1;
                     q_data     = {hold_pc_reg, hold_inst_reg};
                     state_next = IDLE;
                  end
               end
               DROP: begin
                  if (imem_valid) state_next = IDLE;
               end
               default: state_next = IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Front-end producer for the instruction queue FIFO. Holds the PC and issues single-outstanding requests to instruction memory with variable-latency responses. Pushes {pc, inst} pairs into the queue, backs off when the queue is full, and handles branch-mispredict redirects. On a redirect it clears the queue and discards any in-flight response. It sits between the instruction memory port and the issue stage's instruction queue.

Parameters:
ADDR_WIDTH, 32, PC / instruction address width.
INST_WIDTH, 32, instruction word width.
RESET_PC, 0, PC value loaded on reset. Must be 4-byte aligned.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, synchronous, active-high.
imem_req  output  1  one-cycle request pulse to instruction memory.
imem_addr  output  ADDR_WIDTH  request address, equal to pc; valid when imem_req=1.
imem_valid  input  1  one-cycle response strobe; exactly one per request, at least 1 cycle after the request.
imem_data  input  INST_WIDTH  instruction word; valid when imem_valid=1.
redirect_valid  input  1  branch mispredict or redirect strobe.
redirect_pc  input  ADDR_WIDTH  new fetch address; bits [1:0] are ignored and forced to 0.
q_full  input  1  queue full flag.
q_write  output  1  queue push strobe.
q_data  output  ADDR_WIDTH+INST_WIDTH  push payload, {pc, inst}, pc in the MSBs.
q_clear  output  1  queue flush strobe, asserted for one cycle on redirect.

Behaviour:
- State is held in a pc register, a hold register {hold_pc, hold_inst}, and a 2-bit FSM with states IDLE, WAIT, HOLD, DROP.
- Reset: state=IDLE, pc=RESET_PC, hold register=0. While rst=1, all outputs are 0.
- Outputs are combinational from state and inputs:
  - imem_req = (state==IDLE) & !q_full & !redirect_valid.
  - imem_addr = pc.
  - q_clear = redirect_valid.
  - q_write is defined per state below and is never asserted in the same cycle as q_clear.
- IDLE:
  - If imem_req fires, go to WAIT. pc is unchanged.
  - If q_full, stay in IDLE.
- WAIT:
  - On imem_valid with !q_full: q_write=1, q_data={pc, imem_data}, pc<=pc+4, go to IDLE.
  - On imem_valid with q_full: latch {pc, imem_data} into the hold register, pc<=pc+4, go to HOLD.
- HOLD:
  - When !q_full: q_write=1, q_data=hold register, go to IDLE.
  - While q_full, stay in HOLD. No new request is issued.
- DROP:
  - Waits for the response to a request that a redirect has made stale.
  - On imem_valid, discard the data, write nothing, and go to IDLE.
- Redirect (redirect_valid=1), which has priority over every other event in the same cycle:
  - pc<=redirect_pc with bits [1:0]=0, q_clear=1, q_write=0, imem_req=0.
  - From IDLE: stay in IDLE.
  - From HOLD: discard the hold register, go to IDLE.
  - From WAIT without imem_valid in the same cycle: go to DROP, since a response is still owed.
  - From WAIT with imem_valid in the same cycle: discard the response, go to IDLE.
  - From DROP without imem_valid: stay in DROP.
  - From DROP with imem_valid: go to IDLE.
- Arithmetic: pc+4 wraps modulo 2^ADDR_WIDTH, so 0xFFFFFFFC+4 = 0x00000000.
- Throughput: at most one instruction per 2 cycles (request cycle plus response cycle, with memory latency 1). At most one request is outstanding at any time.
- Reset mid-operation: rst in WAIT returns the FSM to IDLE and does not drop the pending response. The memory side must be reset in the same cycle.
- imem_valid arriving in IDLE or HOLD is a protocol violation. It is ignored, and the bench flags it.

Test Plan:
- Reset, RESET_PC=0, memory latency 1, q_full=0 -> imem_req at cycle 1 with addr 0x0. Then q_write pushes {0x0,I0}, {0x4,I1}, {0x8,I2}, one push every 2 cycles.
- q_full=1 before the first request -> imem_req stays 0. Deassert q_full -> request to 0x0 issues the next cycle.
- Response arrives while q_full=1 -> FSM enters HOLD, q_write=0, no new request. Release q_full after 5 cycles -> a single push {0x0,I0}, then the request for 0x4.
- Redirect to 0x100 while in WAIT, memory latency 3 -> q_clear for 1 cycle, the stale response is discarded with no push, and the next imem_addr is 0x100.
- Redirect while in HOLD and a redirect in the same cycle as imem_valid -> nothing is pushed, q_clear=1, and fetch resumes at redirect_pc. redirect_pc=0x103 yields fetch address 0x100.
- pc=0xFFFFFFFC fetch -> the push carries pc 0xFFFFFFFC and the next imem_addr is 0x0. Asserting rst in WAIT -> outputs are 0 and fetch restarts at RESET_PC.
